// File: rtl/parking_pkg.sv
// Shared definitions for the parking exit path.
// Floor codes match what entry control reports. LCD codes match the entry-side display.
// The exit FSM state type lives here so that sub-blocks and the top agree on one encoding.
package parking_pkg;

  localparam logic [1:0] FLR0_NORM   = 2'd0;
  localparam logic [1:0] FLR0_SPEC   = 2'd1;
  localparam logic [1:0] FLR1        = 2'd2;
  localparam logic [1:0] FLR_ILLEGAL = 2'd3;

  localparam logic [3:0] LCD_IDLE  = 4'd0;
  localparam logic [3:0] LCD_WRONG = 4'd2;
  localparam logic [3:0] LCD_BYE   = 4'd3;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSearch  = 3'd1,
    StRelease = 3'd2,
    StGranted = 3'd3,
    StDenied  = 3'd4
  } exit_state_e;

endpackage

// File: rtl/parking_slot_table.sv
// Occupancy table for parked cars.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   wr_en/wr_id/wr_flr      park request; lands in the lowest-index free entry
//   wr_drop                 registered pulse: last wr_en was rejected (full or illegal floor)
//   rd_idx -> rd_*          combinational read port used by the exit search
//   clr_en/clr_idx          invalidate one entry at the clock edge
//   occupied_cnt/table_full number of valid entries, and all-entries-valid flag
module parking_slot_table
  import parking_pkg::*;
#(
  parameter int unsigned SLOTS = 8,
  parameter int unsigned ID_W  = 28,
  parameter int unsigned IDX_W = $clog2(SLOTS),
  parameter int unsigned CNT_W = $clog2(SLOTS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [ID_W-1:0]  wr_id,
  input  logic [1:0]       wr_flr,
  output logic             wr_drop,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [ID_W-1:0]  rd_id,
  output logic [1:0]       rd_flr,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  output logic [CNT_W-1:0] occupied_cnt,
  output logic             table_full
);

  logic [SLOTS-1:0] valid_q, valid_d;
  logic [ID_W-1:0]  id_q  [SLOTS];
  logic [ID_W-1:0]  id_d  [SLOTS];
  logic [1:0]       flr_q [SLOTS];
  logic [1:0]       flr_d [SLOTS];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             accept;
  logic             clr_do;

  // Lowest-index free entry. An entry being cleared this cycle still reads as
  // valid here, so it only becomes free on the following cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign accept = wr_en && (wr_flr != FLR_ILLEGAL) && free_found;
  assign clr_do = clr_en && valid_q[clr_idx];

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    flr_d   = flr_q;
    if (accept) begin
      valid_d[free_idx] = 1'b1;
      id_d[free_idx]    = wr_id;
      flr_d[free_idx]   = wr_flr;
    end
    // Clear never targets the write index: the cleared entry is still valid.
    if (clr_do) begin
      valid_d[clr_idx] = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !clr_do) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!accept && clr_do) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    drop_d = wr_en && !accept;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        id_q[i]  <= '0;
        flr_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      id_q    <= id_d;
      flr_q   <= flr_d;
    end
  end

  assign rd_valid     = valid_q[rd_idx];
  assign rd_id        = id_q[rd_idx];
  assign rd_flr       = flr_q[rd_idx];
  assign wr_drop      = drop_q;
  assign occupied_cnt = cnt_q;
  assign table_full   = (cnt_q == CNT_W'(SLOTS));

endmodule

// File: rtl/parking_exit_controller.sv
// Exit-gate controller. Entry control records granted cars into the slot table.
// An exit request scans the table one entry per cycle. On a hit the entry is freed and a
// one-cycle release pulse is sent to floor bookkeeping. On a miss the wrong-ID indication
// is raised.
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   park_valid/park_id/park_flr    record a granted car; park_drop pulses if rejected
//   exit_req/exit_id               exit request, sampled only when idle
//   busy                           controller not idle
//   release_valid/release_flr      slot-freed pulse and its floor
//   green_led/red_wrong_led        outcome indicators, held HOLD_CYC cycles
//   lcd_state                      display code
//   occupied_cnt/table_full        table occupancy
module parking_exit_controller
  import parking_pkg::*;
#(
  parameter int unsigned SLOTS    = 8,
  parameter int unsigned ID_W     = 28,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       park_valid,
  input  logic [ID_W-1:0]            park_id,
  input  logic [1:0]                 park_flr,
  output logic                       park_drop,
  input  logic                       exit_req,
  input  logic [ID_W-1:0]            exit_id,
  output logic                       busy,
  output logic                       release_valid,
  output logic [1:0]                 release_flr,
  output logic                       green_led,
  output logic                       red_wrong_led,
  output logic [3:0]                 lcd_state,
  output logic [$clog2(SLOTS+1)-1:0] occupied_cnt,
  output logic                       table_full
);

  localparam int unsigned IDX_W = $clog2(SLOTS);
  localparam int unsigned CNT_W = $clog2(SLOTS + 1);
  localparam int unsigned HCW   = $clog2(HOLD_CYC + 1);

  localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(SLOTS - 1);
  localparam logic [HCW-1:0]   LastHold = HCW'(HOLD_CYC - 1);

  exit_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ID_W-1:0]  exit_id_q, exit_id_d;
  logic [1:0]       rel_flr_q, rel_flr_d;
  logic [HCW-1:0]   hold_q, hold_d;

  logic             rd_valid;
  logic [ID_W-1:0]  rd_id;
  logic [1:0]       rd_flr;
  logic             hit;
  logic             clr_en;

  parking_slot_table #(
    .SLOTS (SLOTS),
    .ID_W  (ID_W),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_table (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (park_valid),
    .wr_id        (park_id),
    .wr_flr       (park_flr),
    .wr_drop      (park_drop),
    .rd_idx       (idx_q),
    .rd_valid     (rd_valid),
    .rd_id        (rd_id),
    .rd_flr       (rd_flr),
    .clr_en       (clr_en),
    .clr_idx      (idx_q),
    .occupied_cnt (occupied_cnt),
    .table_full   (table_full)
  );

  assign hit = rd_valid && (rd_id == exit_id_q);

  // idx_q is frozen on a hit, so it doubles as the captured index for the clear.
  assign clr_en = (state_q == StRelease);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    exit_id_d = exit_id_q;
    rel_flr_d = rel_flr_q;
    hold_d    = hold_q;
    unique case (state_q)
      StIdle: begin
        if (exit_req) begin
          exit_id_d = exit_id;
          idx_d     = '0;
          state_d   = StSearch;
        end
      end
      StSearch: begin
        if (hit) begin
          rel_flr_d = rd_flr;
          state_d   = StRelease;
        end else if (idx_q == LastIdx) begin
          hold_d  = '0;
          state_d = StDenied;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StRelease: begin
        hold_d  = '0;
        state_d = StGranted;
      end
      StGranted, StDenied: begin
        if (hold_q == LastHold) begin
          hold_d  = '0;
          state_d = StIdle;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      exit_id_q <= '0;
      rel_flr_q <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      exit_id_q <= exit_id_d;
      rel_flr_q <= rel_flr_d;
      hold_q    <= hold_d;
    end
  end

  // Moore decode from the state register only.
  always_comb begin
    busy          = (state_q != StIdle);
    release_valid = (state_q == StRelease);
    release_flr   = (state_q == StRelease) ? rel_flr_q : 2'd0;
    green_led     = (state_q == StGranted);
    red_wrong_led = (state_q == StDenied);
    lcd_state     = LCD_IDLE;
    if (state_q == StGranted) begin
      lcd_state = LCD_BYE;
    end else if (state_q == StDenied) begin
      lcd_state = LCD_WRONG;
    end
  end

endmodule

// File: tb/tb_parking_exit_controller.sv
// Self-checking bench for parking_exit_controller. A simple table model (arrays) predicts
// placement, drops and occupancy. Exit outcomes and their cycle timing are derived from
// the position of the first matching entry.
module tb_parking_exit_controller;

  localparam int SLOTS = 8;
  localparam int ID_W  = 28;
  localparam int HOLD  = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            park_valid = 1'b0;
  logic [ID_W-1:0] park_id = '0;
  logic [1:0]      park_flr = '0;
  logic            park_drop;
  logic            exit_req = 1'b0;
  logic [ID_W-1:0] exit_id = '0;
  logic            busy;
  logic            release_valid;
  logic [1:0]      release_flr;
  logic            green_led;
  logic            red_wrong_led;
  logic [3:0]      lcd_state;
  logic [3:0]      occupied_cnt;
  logic            table_full;

  int total = 0;
  int bad   = 0;

  // Reference model of the occupancy table
  bit              m_valid [SLOTS];
  logic [ID_W-1:0] m_id    [SLOTS];
  logic [1:0]      m_flr   [SLOTS];
  bit              m_drop = 1'b0;
  bit              m_clr  = 1'b0;
  int              m_clr_idx = 0;

  parking_exit_controller #(
    .SLOTS    (SLOTS),
    .ID_W     (ID_W),
    .HOLD_CYC (HOLD)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .park_valid    (park_valid),
    .park_id       (park_id),
    .park_flr      (park_flr),
    .park_drop     (park_drop),
    .exit_req      (exit_req),
    .exit_id       (exit_id),
    .busy          (busy),
    .release_valid (release_valid),
    .release_flr   (release_flr),
    .green_led     (green_led),
    .red_wrong_led (red_wrong_led),
    .lcd_state     (lcd_state),
    .occupied_cnt  (occupied_cnt),
    .table_full    (table_full)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got running, required finished)");
    $fatal(1, "watchdog");
  end

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < SLOTS; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < SLOTS; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  task automatic m_clear_all();
    for (int i = 0; i < SLOTS; i++) m_valid[i] = 1'b0;
    m_drop = 1'b0;
    m_clr  = 1'b0;
  endtask

  // Advance one clock. The model applies the same edge, using the inputs currently driven.
  task automatic tick();
    int f;
    bit drop = 1'b0;
    if (park_valid) begin
      f = m_free();
      if (park_flr == 2'd3 || f < 0) begin
        drop = 1'b1;
      end else begin
        m_valid[f] = 1'b1;
        m_id[f]    = park_id;
        m_flr[f]   = park_flr;
      end
    end
    if (m_clr) begin
      m_valid[m_clr_idx] = 1'b0;
      m_clr = 1'b0;
    end
    m_drop = drop;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    m_clear_all();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic park(input logic [ID_W-1:0] id, input logic [1:0] flr);
    park_valid = 1'b1;
    park_id    = id;
    park_flr   = flr;
    tick();
    park_valid = 1'b0;
    total++;
    if (park_drop !== m_drop) begin
      bad++;
      $display("FAIL park_drop id=%h flr=%0d got=%b expected=%b", id, flr, park_drop, m_drop);
    end
    total++;
    if (occupied_cnt !== 4'(m_count()) || table_full !== (m_count() == SLOTS)) begin
      bad++;
      $display("FAIL park_occupancy id=%h got cnt=%0d full=%b expected cnt=%0d full=%b",
               id, occupied_cnt, table_full, m_count(), m_count() == SLOTS);
    end
  endtask

  // One exit transaction from cycle 0 (exit_req sampled) until two cycles after idle.
  // Optional: park_len parks starting at cycle park_cyc, and an ignored exit_req at ghost_cyc.
  task automatic do_exit(input logic [ID_W-1:0] id, input int park_cyc, input int park_len,
                         input logic [ID_W-1:0] pid, input logic [1:0] pflr,
                         input int ghost_cyc);
    int         hit = -1;
    int         rel_c;
    int         idle_c;
    logic [1:0] exp_flr;
    logic [9:0] exp_v;
    logic [9:0] got_v;
    for (int i = 0; i < SLOTS; i++) begin
      if (hit < 0 && m_valid[i] && m_id[i] == id) hit = i;
    end
    exp_flr = (hit >= 0) ? m_flr[hit] : 2'd0;
    rel_c   = (hit >= 0) ? hit + 2 : -1;
    idle_c  = (hit >= 0) ? hit + 3 + HOLD : SLOTS + HOLD + 1;
    exit_req = 1'b1;
    exit_id  = id;
    tick();
    exit_req = 1'b0;
    exit_id  = ID_W'($urandom);
    for (int c = 1; c <= idle_c + 2; c++) begin
      bit         grn;
      bit         red;
      logic [3:0] lcd;
      grn = (hit >= 0) && c >= hit + 3 && c < idle_c;
      red = (hit < 0) && c >= SLOTS + 1 && c < idle_c;
      lcd = grn ? 4'd3 : (red ? 4'd2 : 4'd0);
      exp_v = {c < idle_c, c == rel_c, grn, red, lcd, (c == rel_c) ? exp_flr : 2'd0};
      got_v = {busy, release_valid, green_led, red_wrong_led, lcd_state,
               release_valid ? release_flr : 2'd0};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL exit_outputs id=%h cycle=%0d got busy,rel,grn,red,lcd,flr=%b expected=%b",
                 id, c, got_v, exp_v);
      end
      total++;
      if (occupied_cnt !== 4'(m_count()) || table_full !== (m_count() == SLOTS)) begin
        bad++;
        $display("FAIL exit_occupancy id=%h cycle=%0d got cnt=%0d full=%b expected cnt=%0d",
                 id, c, occupied_cnt, table_full, m_count());
      end
      total++;
      if (park_drop !== m_drop) begin
        bad++;
        $display("FAIL exit_park_drop id=%h cycle=%0d got=%b expected=%b",
                 id, c, park_drop, m_drop);
      end
      park_valid = (park_cyc > 0) && c >= park_cyc && c < park_cyc + park_len;
      park_id    = pid + ID_W'(c - park_cyc);
      park_flr   = pflr;
      exit_req   = (c == ghost_cyc);
      exit_id    = id;
      m_clr      = (c == rel_c);
      m_clr_idx  = hit;
      tick();
      park_valid = 1'b0;
      exit_req   = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [15:0] got;
    #2;
    reset_n = 1'b0;
    #1;
    got = {busy, release_valid, release_flr, green_led, red_wrong_led, lcd_state,
           occupied_cnt, table_full, park_drop};
    total++;
    if (got !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%b expected=%b", got, 16'h0);
    end
    m_clear_all();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_hit();
    park(28'h1234567, 2'd2);
    do_exit(28'h1234567, -1, 0, '0, 2'd0, -1);
  endtask

  task automatic test_miss_empty();
    do_exit(28'hABCDEF0, -1, 0, '0, 2'd0, -1);
  endtask

  task automatic test_full();
    do_reset();
    park(28'h0000055, 2'd3);
    for (int i = 0; i < SLOTS; i++) park(ID_W'(28'h100 + i), 2'(i % 3));
    park(28'h0000200, 2'd1);
    // Parks in the RELEASE cycle (dropped) and the cycle after (takes the freed slot 7)
    do_exit(28'h0000107, 9, 2, 28'h0000777, 2'd1, -1);
    do_exit(28'h0000778, -1, 0, '0, 2'd0, -1);
  endtask

  task automatic test_duplicate();
    do_reset();
    park(28'h00000D0, 2'd0);
    park(28'h00000D1, 2'd1);
    park(28'h00000D2, 2'd2);
    park(28'h00000D0, 2'd2);
    do_exit(28'h00000D0, -1, 0, '0, 2'd0, -1);
    do_exit(28'h00000D0, -1, 0, '0, 2'd0, -1);
  endtask

  task automatic test_back_to_back();
    // D2 sits in slot 2: release in cycle 4 coincides with a park; exit_req during GRANTED.
    do_exit(28'h00000D2, 4, 1, 28'h00000E0, 2'd0, 6);
  endtask

  task automatic test_reset_mid_search();
    logic [15:0] got;
    do_reset();
    park(28'h0000F00, 2'd1);
    exit_req = 1'b1;
    exit_id  = 28'h0000F55;
    tick();
    exit_req = 1'b0;
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_search_busy got=%b expected=1", busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    got = {busy, release_valid, release_flr, green_led, red_wrong_led, lcd_state,
           occupied_cnt, table_full, park_drop};
    total++;
    if (got !== 16'h0) begin
      bad++;
      $display("FAIL mid_search_reset got=%b expected=%b", got, 16'h0);
    end
    m_clear_all();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    do_exit(28'h0000F00, -1, 0, '0, 2'd0, -1);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 40; n++) begin
      logic [ID_W-1:0] id;
      id = ID_W'(28'hC00 + $urandom_range(0, 5));
      if (m_count() == SLOTS && $urandom_range(0, 3) == 0) do_reset();
      if ($urandom_range(0, 2) < 2) begin
        park(id, 2'($urandom_range(0, 3)));
      end else if ($urandom_range(0, 3) == 0) begin
        // Injected IDs carry bit 27 so they never match the pool being exited.
        do_exit(id, $urandom_range(1, 12), $urandom_range(1, 2),
                ID_W'(28'h8000000 | ($urandom & 28'hFFFF)), 2'($urandom_range(0, 3)),
                $urandom_range(1, 6));
      end else begin
        do_exit(id, -1, 0, '0, 2'd0, -1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss_empty();
    test_full();
    test_duplicate();
    test_back_to_back();
    test_reset_mid_search();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parking_exit_controller.md
# parking_exit_controller

Exit-gate controller for the parking system; the reader side of the entry path. Entry control reports every granted car (ID plus assigned floor) into this block's occupancy table. At the exit gate, a presented ID is searched in that table. A hit frees the slot and emits a one-cycle release (floor decrement) toward the floor bookkeeping logic; a miss raises the wrong-ID indication. Indicator and LCD codes match the entry side.

## Interface
Parameters:
- SLOTS, 8, occupancy table depth (≥2)
- ID_W, 28, car ID width
- HOLD_CYC, 4, cycles an outcome indicator is held (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- park_valid  in  1  entry side granted a car this cycle; record it
- park_id  in  ID_W  ID of granted car
- park_flr  in  2  assigned floor: 0 = floor0 normal, 1 = floor0 special, 2 = floor1 (3 is illegal, dropped)
- park_drop  out  1  one-cycle pulse, park_valid rejected (table full or park_flr = 3)
- exit_req  in  1  car at exit gate; sampled only in IDLE
- exit_id  in  ID_W  ID presented at exit
- busy  out  1  high in every state but IDLE
- release_valid  out  1  one-cycle pulse, slot freed
- release_flr  out  2  floor of freed slot, valid with release_valid
- green_led  out  1  exit granted
- red_wrong_led  out  1  ID not parked
- lcd_state  out  4  0 = idle, 3 = goodbye, 2 = wrong ID
- occupied_cnt  out  $clog2(SLOTS+1)  valid table entries
- table_full  out  1  occupied_cnt == SLOTS

## Operation
- Table: SLOTS entries of {valid, id, flr}.
- Park write is independent of the FSM and accepted in any state. An accepted park_valid writes the lowest-index invalid entry at the clock edge. If no entry is free or park_flr = 3, it is dropped and park_drop pulses the next cycle.
- Duplicate IDs are stored. Exit frees the lowest-index match.
- FSM states:
  - IDLE: exit_req=1 latches exit_id, sets idx=0, and moves to SEARCH.
  - SEARCH: compares entry[idx] (valid && id==latched). On a match, capture idx/flr and go to RELEASE. On no match with idx==SLOTS-1, go to DENIED. Otherwise idx+1.
  - RELEASE: exactly one cycle. release_valid=1, release_flr=captured flr; the entry's valid clears at the cycle end. Then go to GRANTED.
  - GRANTED: green_led=1, lcd_state=3, for HOLD_CYC cycles, then IDLE.
  - DENIED: red_wrong_led=1, lcd_state=2, for HOLD_CYC cycles, then IDLE.
- exit_req outside IDLE is ignored, not queued.
- Outputs are Moore-decoded from state; no glitches on LEDs between states.
- occupied_cnt changes as follows:
  - +1 on an accepted write.
  - −1 at the end of RELEASE.
  - Both in the same cycle: unchanged.
  - It never wraps.
- A slot being released is not free until the cycle after RELEASE. A park_valid in the RELEASE cycle with the table full is dropped.
- A park write during SEARCH to an index already scanned is not re-searched.
- Reset (async, any state): FSM to IDLE, all entries invalid, idx=0, hold counter 0, all outputs 0 (lcd_state=0, occupied_cnt=0).

## Timing
- Cycle 0: exit_req sampled in IDLE.
- Entry k is compared in cycle k+1.
- Hit at k: release_valid in cycle k+2; green_led in cycles k+3 … k+2+HOLD_CYC; busy low from cycle k+3+HOLD_CYC.
- Miss: SEARCH cycles 1…SLOTS; red_wrong_led in cycles SLOTS+1 … SLOTS+HOLD_CYC.
- Park write is visible to the comparator and to occupied_cnt one cycle after the park_valid edge.

## Structure
- Shared package parking_pkg:
  - floor codes (FLR0_NORM, FLR0_SPEC, FLR1)
  - LCD codes (LCD_IDLE=0, LCD_WRONG=2, LCD_BYE=3)
  - exit FSM state enum
- One sub-module, parking_slot_table: storage, lowest-free priority encoder, read port at idx, clear port, occupancy counter.
- The top level holds the FSM, idx counter, hold counter and output decode.

## Test plan
- Park ID 0x1234567 floor 2, then exit_req with the same ID → release_valid in cycle 2 with release_flr=2, green_led cycles 3–6, occupied_cnt 1→0.
- Exit of ID 0xABCDEF0 with an empty table → no release_valid, red_wrong_led cycles 9–12 (SLOTS=8), lcd_state=2, then IDLE.
- Fill 8 slots, then a 9th park_valid → park_drop pulse, table_full=1, occupied_cnt stays 8. Exit the ID in slot 7 → release at cycle 9. A park in that RELEASE cycle is dropped; the next-cycle park lands in slot 7.
- Duplicate ID parked in slots 0 and 3 → first exit frees slot 0 only; second exit frees slot 3.
- Park write and RELEASE in the same cycle → occupied_cnt unchanged. exit_req pulsed during GRANTED → ignored.
- reset_n asserted mid-SEARCH → immediate IDLE, outputs 0, table empty; a following exit of the previously parked ID is denied.
